reorder_buffer: RTL and testbench

- Circular reorder buffer at the receiving end of the dispatch stage's ROB allocation.
- Dispatch writes up to two entries per cycle at rob_tail, in program order. Execution units mark entries done by index.
- Completed entries retire in order from rob_head, up to two per cycle, to the register file.
- Exports rob_head/rob_tail, from which dispatch derives its own full check (tail+1==head, tail+2==head).

---
 rtl/reorder_buffer.sv | 167 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: dual in-order allocation at the tail, indexed writeback,
// and dual in-order retirement from the head. One slot is kept free so tail==head means empty.
module reorder_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_a_valid,
  input  logic [4:0]        alloc_a_rd,
  input  logic              alloc_a_regwrite,
  input  logic              alloc_b_valid,
  input  logic [4:0]        alloc_b_rd,
  input  logic              alloc_b_regwrite,
  input  logic              wb0_valid,
  input  logic [IDX_W-1:0]  wb0_idx,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  input  logic [IDX_W-1:0]  wb1_idx,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              flush,
  output logic [IDX_W-1:0]  rob_head,
  output logic [IDX_W-1:0]  rob_tail,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_empty,
  output logic              commit0_valid,
  output logic [4:0]        commit0_rd,
  output logic              commit0_regwrite,
  output logic [DATA_W-1:0] commit0_data,
  output logic              commit1_valid,
  output logic [4:0]        commit1_rd,
  output logic              commit1_regwrite,
  output logic [DATA_W-1:0] commit1_data,
  output logic              alloc_err
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] done_q, done_d;
  logic [ENTRIES-1:0] regwrite_q, regwrite_d;
  logic [4:0]         rd_q   [ENTRIES];
  logic [4:0]         rd_d   [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [DATA_W-1:0]  data_d [ENTRIES];
  logic [IDX_W-1:0]   head_q, head_d;
  logic [IDX_W-1:0]   tail_q, tail_d;
  logic [IDX_W:0]     count_q, count_d;
  logic               alloc_err_q, alloc_err_d;

  logic [IDX_W-1:0]   head_p1;
  logic               c0, c1;
  logic [1:0]         n_alloc, n_commit;
  logic [IDX_W+1:0]   occ;
  logic               overflow;
  logic               a_we, b_we;
  logic [IDX_W-1:0]   a_idx, b_idx;
  logic               wb0_hit, wb1_hit;

  // Retirement candidates and commit ports; flush suppresses retirement entirely.
  always_comb begin
    head_p1          = head_q + IDX_W'(1);
    c0               = valid_q[head_q] & done_q[head_q] & ~flush;
    c1               = c0 & valid_q[head_p1] & done_q[head_p1];
    commit0_valid    = c0;
    commit0_rd       = c0 ? rd_q[head_q] : 5'd0;
    commit0_regwrite = c0 & regwrite_q[head_q];
    commit0_data     = c0 ? data_q[head_q] : {DATA_W{1'b0}};
    commit1_valid    = c1;
    commit1_rd       = c1 ? rd_q[head_p1] : 5'd0;
    commit1_regwrite = c1 & regwrite_q[head_p1];
    commit1_data     = c1 ? data_q[head_p1] : {DATA_W{1'b0}};
  end

  // Next-state: writeback, then retirement clears, then allocation; flush overrides all.
  always_comb begin
    n_alloc  = {1'b0, alloc_a_valid} + {1'b0, alloc_b_valid};
    n_commit = {1'b0, c0} + {1'b0, c1};
    occ      = (IDX_W+2)'(count_q) + (IDX_W+2)'(n_alloc) - (IDX_W+2)'(n_commit);
    overflow = (occ > (IDX_W+2)'(ENTRIES-1));
    a_idx    = tail_q;
    b_idx    = tail_q + IDX_W'(alloc_a_valid);
    a_we     = alloc_a_valid & ~overflow;
    b_we     = alloc_b_valid & ~overflow;
    // a slot being allocated is never valid, but the guard makes allocation priority explicit
    wb0_hit  = wb0_valid & valid_q[wb0_idx] & ~(a_we & (wb0_idx == a_idx))
               & ~(b_we & (wb0_idx == b_idx));
    wb1_hit  = wb1_valid & valid_q[wb1_idx] & ~(a_we & (wb1_idx == a_idx))
               & ~(b_we & (wb1_idx == b_idx));

    valid_d     = valid_q;
    done_d      = done_q;
    regwrite_d  = regwrite_q;
    rd_d        = rd_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    alloc_err_d = alloc_err_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // wb1 applied first so wb0 overrides it on a shared index
      done_d[wb1_idx]  = done_d[wb1_idx] | wb1_hit;
      data_d[wb1_idx]  = wb1_hit ? wb1_data : data_d[wb1_idx];
      done_d[wb0_idx]  = done_d[wb0_idx] | wb0_hit;
      data_d[wb0_idx]  = wb0_hit ? wb0_data : data_d[wb0_idx];

      valid_d[head_q]  = valid_d[head_q] & ~c0;
      done_d[head_q]   = done_d[head_q] & ~c0;
      valid_d[head_p1] = valid_d[head_p1] & ~c1;
      done_d[head_p1]  = done_d[head_p1] & ~c1;

      valid_d[a_idx]    = valid_d[a_idx] | a_we;
      done_d[a_idx]     = done_d[a_idx] & ~a_we;
      rd_d[a_idx]       = a_we ? alloc_a_rd : rd_d[a_idx];
      regwrite_d[a_idx] = a_we ? alloc_a_regwrite : regwrite_d[a_idx];
      valid_d[b_idx]    = valid_d[b_idx] | b_we;
      done_d[b_idx]     = done_d[b_idx] & ~b_we;
      rd_d[b_idx]       = b_we ? alloc_b_rd : rd_d[b_idx];
      regwrite_d[b_idx] = b_we ? alloc_b_regwrite : regwrite_d[b_idx];

      head_d      = head_q + IDX_W'(n_commit);
      tail_d      = tail_q + (overflow ? IDX_W'(0) : IDX_W'(n_alloc));
      count_d     = count_q + (overflow ? (IDX_W+1)'(0) : (IDX_W+1)'(n_alloc))
                    - (IDX_W+1)'(n_commit);
      alloc_err_d = alloc_err_q | (overflow & (n_alloc != 2'd0));
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      alloc_err_q <= alloc_err_d;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    regwrite_q <= regwrite_d;
    rd_q       <= rd_d;
    data_q     <= data_d;
  end

  assign rob_head  = head_q;
  assign rob_tail  = tail_q;
  assign rob_count = count_q;
  assign rob_empty = (count_q == '0);
  assign alloc_err = alloc_err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed table-driven bench for reorder_buffer plus hand-written wrap, flush and reset sequences.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_a_valid, alloc_a_regwrite, alloc_b_valid, alloc_b_regwrite;
  logic [4:0]  alloc_a_rd, alloc_b_rd;
  logic        wb0_valid, wb1_valid, flush;
  logic [3:0]  wb0_idx, wb1_idx;
  logic [31:0] wb0_data, wb1_data;
  logic [3:0]  rob_head, rob_tail;
  logic [4:0]  rob_count;
  logic        rob_empty, alloc_err;
  logic        commit0_valid, commit0_regwrite, commit1_valid, commit1_regwrite;
  logic [4:0]  commit0_rd, commit1_rd;
  logic [31:0] commit0_data, commit1_data;

  int checks = 0;
  int failures = 0;

  reorder_buffer #(.ENTRIES(16), .IDX_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_a_valid(alloc_a_valid), .alloc_a_rd(alloc_a_rd), .alloc_a_regwrite(alloc_a_regwrite),
    .alloc_b_valid(alloc_b_valid), .alloc_b_rd(alloc_b_rd), .alloc_b_regwrite(alloc_b_regwrite),
    .wb0_valid(wb0_valid), .wb0_idx(wb0_idx), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_idx(wb1_idx), .wb1_data(wb1_data),
    .flush(flush),
    .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count), .rob_empty(rob_empty),
    .commit0_valid(commit0_valid), .commit0_rd(commit0_rd),
    .commit0_regwrite(commit0_regwrite), .commit0_data(commit0_data),
    .commit1_valid(commit1_valid), .commit1_rd(commit1_rd),
    .commit1_regwrite(commit1_regwrite), .commit1_data(commit1_data),
    .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [4:0] ard; logic arw;
    logic bv; logic [4:0] brd; logic brw;
    logic w0v; logic [3:0] w0i; logic [31:0] w0d;
    logic w1v; logic [3:0] w1i; logic [31:0] w1d;
    logic fl;
  } in_t;

  typedef struct {
    logic [3:0] h; logic [3:0] t; logic [4:0] cnt;
    logic c0v; logic [4:0] c0rd; logic c0rw; logic [31:0] c0d;
    logic c1v; logic [4:0] c1rd; logic c1rw; logic [31:0] c1d;
    logic err;
  } ex_t;

  typedef struct { in_t i; ex_t e; } vec_t;

  function automatic in_t mk_in(input logic av, input logic [4:0] ard, input logic arw,
                                input logic bv, input logic [4:0] brd, input logic brw,
                                input logic w0v, input logic [3:0] w0i, input logic [31:0] w0d,
                                input logic w1v, input logic [3:0] w1i, input logic [31:0] w1d,
                                input logic fl);
    in_t v;
    v.av = av; v.ard = ard; v.arw = arw; v.bv = bv; v.brd = brd; v.brw = brw;
    v.w0v = w0v; v.w0i = w0i; v.w0d = w0d; v.w1v = w1v; v.w1i = w1i; v.w1d = w1d; v.fl = fl;
    return v;
  endfunction

  function automatic ex_t mk_ex(input logic [3:0] h, input logic [3:0] t, input logic [4:0] cnt,
                                input logic c0v, input logic [4:0] c0rd, input logic c0rw,
                                input logic [31:0] c0d,
                                input logic c1v, input logic [4:0] c1rd, input logic c1rw,
                                input logic [31:0] c1d, input logic err);
    ex_t e;
    e.h = h; e.t = t; e.cnt = cnt; e.c0v = c0v; e.c0rd = c0rd; e.c0rw = c0rw; e.c0d = c0d;
    e.c1v = c1v; e.c1rd = c1rd; e.c1rw = c1rw; e.c1d = c1d; e.err = err;
    return e;
  endfunction

  function automatic in_t idle();
    return mk_in(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endfunction

  function automatic ex_t quiet(input logic [3:0] h, input logic [3:0] t, input logic [4:0] cnt,
                                input logic err);
    return mk_ex(h, t, cnt, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, err);
  endfunction

  task automatic drive(input in_t v);
    alloc_a_valid = v.av; alloc_a_rd = v.ard; alloc_a_regwrite = v.arw;
    alloc_b_valid = v.bv; alloc_b_rd = v.brd; alloc_b_regwrite = v.brw;
    wb0_valid = v.w0v; wb0_idx = v.w0i; wb0_data = v.w0d;
    wb1_valid = v.w1v; wb1_idx = v.w1i; wb1_data = v.w1d;
    flush = v.fl;
  endtask

  task automatic step(input in_t v);
    @(negedge clk);
    drive(v);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_ex(input string nm, input ex_t e);
    chk({nm, ".head"},  32'(rob_head),  32'(e.h));
    chk({nm, ".tail"},  32'(rob_tail),  32'(e.t));
    chk({nm, ".count"}, 32'(rob_count), 32'(e.cnt));
    chk({nm, ".empty"}, 32'(rob_empty), 32'(e.cnt == 5'd0));
    chk({nm, ".c0v"},   32'(commit0_valid), 32'(e.c0v));
    chk({nm, ".c1v"},   32'(commit1_valid), 32'(e.c1v));
    chk({nm, ".err"},   32'(alloc_err), 32'(e.err));
    if (e.c0v) begin
      chk({nm, ".c0rd"}, 32'(commit0_rd), 32'(e.c0rd));
      chk({nm, ".c0rw"}, 32'(commit0_regwrite), 32'(e.c0rw));
      chk({nm, ".c0d"},  commit0_data, e.c0d);
    end
    if (e.c1v) begin
      chk({nm, ".c1rd"}, 32'(commit1_rd), 32'(e.c1rd));
      chk({nm, ".c1rw"}, 32'(commit1_regwrite), 32'(e.c1rw));
      chk({nm, ".c1d"},  commit1_data, e.c1d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(idle());
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  vec_t tbl[16];
  in_t  ab;
  logic [31:0] r;

  initial begin
    // Single flow, out-of-order dual completion, same-index writebacks, B-only alloc,
    // writebacks to unallocated / being-allocated slots.
    tbl[0]  = '{mk_in(1, 5'd5, 1, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0), quiet(4'd0, 4'd0, 5'd0, 0)};
    tbl[1]  = '{mk_in(0, 5'd0, 0, 0, 5'd0, 0, 1, 4'd0, 32'hDEADBEEF, 0, 4'd0, 32'd0, 0), quiet(4'd0, 4'd1, 5'd1, 0)};
    tbl[2]  = '{idle(), mk_ex(4'd0, 4'd1, 5'd1, 1, 5'd5, 1, 32'hDEADBEEF, 0, 5'd0, 0, 32'd0, 0)};
    tbl[3]  = '{mk_in(1, 5'd7, 1, 1, 5'd9, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0), quiet(4'd1, 4'd1, 5'd0, 0)};
    tbl[4]  = '{mk_in(0, 5'd0, 0, 0, 5'd0, 0, 1, 4'd2, 32'h22, 0, 4'd0, 32'd0, 0), quiet(4'd1, 4'd3, 5'd2, 0)};
    tbl[5]  = '{idle(), quiet(4'd1, 4'd3, 5'd2, 0)};
    tbl[6]  = '{mk_in(0, 5'd0, 0, 0, 5'd0, 0, 0, 4'd0, 32'd0, 1, 4'd1, 32'h11, 0), quiet(4'd1, 4'd3, 5'd2, 0)};
    tbl[7]  = '{idle(), mk_ex(4'd1, 4'd3, 5'd2, 1, 5'd7, 1, 32'h11, 1, 5'd9, 0, 32'h22, 0)};
    tbl[8]  = '{mk_in(1, 5'd1, 1, 0, 5'd0, 0, 1, 4'd5, 32'h55, 0, 4'd0, 32'd0, 0), quiet(4'd3, 4'd3, 5'd0, 0)};
    tbl[9]  = '{mk_in(0, 5'd0, 0, 1, 5'd4, 1, 1, 4'd3, 32'h1, 1, 4'd3, 32'h2, 0), quiet(4'd3, 4'd4, 5'd1, 0)};
    tbl[10] = '{idle(), mk_ex(4'd3, 4'd5, 5'd2, 1, 5'd1, 1, 32'h1, 0, 5'd0, 0, 32'd0, 0)};
    tbl[11] = '{mk_in(1, 5'd6, 0, 0, 5'd0, 0, 1, 4'd4, 32'h44, 1, 4'd5, 32'h99, 0), quiet(4'd4, 4'd5, 5'd1, 0)};
    tbl[12] = '{idle(), mk_ex(4'd4, 4'd6, 5'd2, 1, 5'd4, 1, 32'h44, 0, 5'd0, 0, 32'd0, 0)};
    tbl[13] = '{mk_in(0, 5'd0, 0, 0, 5'd0, 0, 1, 4'd5, 32'h55, 0, 4'd0, 32'd0, 0), quiet(4'd5, 4'd6, 5'd1, 0)};
    tbl[14] = '{idle(), mk_ex(4'd5, 4'd6, 5'd1, 1, 5'd6, 0, 32'h55, 0, 5'd0, 0, 32'd0, 0)};
    tbl[15] = '{idle(), quiet(4'd6, 4'd6, 5'd0, 0)};

    // Reset held with random inputs, then released.
    rst_n = 1'b0;
    drive(idle());
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      r = $urandom;
      drive(mk_in(r[0], r[5:1], r[6], r[7], r[12:8], r[13], r[14], r[18:15], $urandom,
                  r[19], r[23:20], $urandom, r[24]));
      #1;
      check_ex("rst_hold", quiet(4'd0, 4'd0, 5'd0, 0));
    end
    @(negedge clk);
    drive(idle());
    rst_n = 1'b1;
    #1;
    check_ex("rst_release", quiet(4'd0, 4'd0, 5'd0, 0));
    step(idle());
    check_ex("rst_idle", quiet(4'd0, 4'd0, 5'd0, 0));

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].i);
      check_ex($sformatf("vec%0d", i), tbl[i].e);
    end

    // Fill to capacity, overflow, retire two, wrap the tail.
    do_reset();
    ab = mk_in(1, 5'd1, 1, 1, 5'd2, 1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
    for (int k = 0; k < 7; k++) step(ab);
    step(mk_in(1, 5'd3, 1, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0));
    step(idle());
    check_ex("full", quiet(4'd0, 4'd15, 5'd15, 0));
    step(mk_in(1, 5'd3, 1, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0));
    check_ex("over_cyc", quiet(4'd0, 4'd15, 5'd15, 0));
    step(idle());
    check_ex("over_drop", quiet(4'd0, 4'd15, 5'd15, 1));
    step(mk_in(0, 5'd0, 0, 0, 5'd0, 0, 1, 4'd0, 32'hA0, 1, 4'd1, 32'hA1, 0));
    step(idle());
    check_ex("full_retire", mk_ex(4'd0, 4'd15, 5'd15, 1, 5'd1, 1, 32'hA0, 1, 5'd2, 1, 32'hA1, 1));
    step(mk_in(1, 5'd10, 1, 1, 5'd11, 1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0));
    check_ex("wrap_pre", quiet(4'd2, 4'd15, 5'd13, 1));
    step(idle());
    check_ex("wrap_post", quiet(4'd2, 4'd1, 5'd15, 1));

    // Plain flush from a full, wrapped buffer; sticky error survives.
    step(mk_in(0, 5'd0, 0, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1));
    step(idle());
    check_ex("flush_full", quiet(4'd0, 4'd0, 5'd0, 1));

    // Flush with six live entries, head done, plus same-cycle alloc and writeback.
    ab = mk_in(1, 5'd2, 1, 1, 5'd3, 1, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
    for (int k = 0; k < 3; k++) step(ab);
    step(mk_in(0, 5'd0, 0, 0, 5'd0, 0, 1, 4'd0, 32'hF0, 1, 4'd2, 32'hF2, 0));
    check_ex("pre_flush", quiet(4'd0, 4'd6, 5'd6, 1));
    step(mk_in(1, 5'd8, 1, 0, 5'd0, 0, 1, 4'd1, 32'hF1, 0, 4'd0, 32'd0, 1));
    check_ex("flush_cyc", quiet(4'd0, 4'd6, 5'd6, 1));
    step(idle());
    check_ex("flush_after", quiet(4'd0, 4'd0, 5'd0, 1));
    step(ab);
    step(idle());
    check_ex("flush_stale", quiet(4'd0, 4'd2, 5'd2, 1));

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    drive(mk_in(1, 5'd4, 1, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check_ex("async_rst", quiet(4'd0, 4'd0, 5'd0, 0));
    step(idle());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_ex("async_rel", quiet(4'd0, 4'd0, 5'd0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
